apb4_slave_if_ws: RTL and testbench

//  Parametrised APB4 slave front-end bridging APB to a simple register request/ready interface.

---
 rtl/apb4_slv_pkg.sv | 25 ++
 rtl/apb4_slv_wait_cnt.sv | 59 +++++
 rtl/apb4_slave_if_ws.sv | 226 ++++++++++++++++++++++
 tb/tb_apb4_slave_if_ws.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_slv_pkg.sv
// -----------------------------------------------------------------------------
// apb4_slv_pkg
// Shared types and helpers for the APB4 slave front-end (apb4_slave_if_ws)
// and its wait/timeout counter.
//   state_e      : transfer FSM states
//   RESP_*       : PSLVERR encodings
//   strb_width() : byte-strobe width for a given data width
// -----------------------------------------------------------------------------
package apb4_slv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   localparam logic RESP_OKAY   = 1'b0;
   localparam logic RESP_SLVERR = 1'b1;

   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/apb4_slv_wait_cnt.sv
// -----------------------------------------------------------------------------
// apb4_slv_wait_cnt
// Saturating cycle counter for the register-access phase of an APB transfer.
// Counts up while enabled, stops at TIMEOUT (never wraps).
//   pclk, preset : clock, asynchronous active-high reset
//   clr          : synchronous clear to 0 (wins over en)
//   en           : count one cycle
//   min_done     : count >= WAIT_CYCLES (minimum wait states served)
//   timeout      : count == TIMEOUT
// -----------------------------------------------------------------------------
module apb4_slv_wait_cnt #(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned TIMEOUT     = 16
) (
   input  logic pclk,
   input  logic preset,
   input  logic clr,
   input  logic en,
   output logic min_done,
   output logic timeout
);

   localparam int unsigned      CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != TIMEOUT_C)) begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of process ordering.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // With no minimum wait the threshold is trivially met; avoid a constant
   // comparison against zero.
   generate
      if (WAIT_CYCLES == 0) begin : g_no_wait
         assign min_done = 1'b1;
      end else begin : g_wait
         assign min_done = (count_q >= CNT_W'(WAIT_CYCLES));
      end
   endgenerate

   assign timeout = (count_q == TIMEOUT_C);

endmodule

// File: rtl/apb4_slave_if_ws.sv
// -----------------------------------------------------------------------------
// apb4_slave_if_ws
// APB4 slave front-end that turns an APB transfer into a one-cycle register
// request (read_en / write_en) and waits for reg_ready. Adds WAIT_CYCLES
// minimum wait states, a TIMEOUT on reg_ready and an address-range check;
// timeout and out-of-range accesses complete with PSLVERR. All outputs are
// registered. FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//
// Optional feature (macro APB4_SLV_PPROT_CHECK_EN):
//   defined   : unprivileged writes (pprot[0]=0) are rejected like an
//               out-of-range address (no write_en, PSLVERR).
//   undefined : pprot is ignored.
//
// Ports
//   pclk, preset          clock, asynchronous active-high reset
//   psel, penable, pwrite APB control
//   paddr, pwdata, pstrb  APB address / write data / byte strobes
//   pprot                 APB protection attributes
//   prdata, pready,       APB response
//   pslverr
//   addr, wdata,          register request, held from request to response
//   byte_strobe           (byte_strobe is 0 for reads)
//   read_en, write_en     one-cycle register request pulses
//   rdata, reg_ready      register response
// -----------------------------------------------------------------------------
module apb4_slave_if_ws
   import apb4_slv_pkg::*;
#(
   parameter int unsigned ADDRWIDTH   = 12,
   parameter int unsigned DATAWIDTH   = 32,
   parameter int unsigned ADDR_LIMIT  = 'hFFC,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned TIMEOUT     = 16
) (
   input  logic                             pclk,
   input  logic                             preset,
   input  logic                             psel,
   input  logic [ADDRWIDTH-1:0]             paddr,
   input  logic                             penable,
   input  logic                             pwrite,
   input  logic [DATAWIDTH-1:0]             pwdata,
   input  logic [strb_width(DATAWIDTH)-1:0] pstrb,
   input  logic [2:0]                       pprot,
   output logic [DATAWIDTH-1:0]             prdata,
   output logic                             pready,
   output logic                             pslverr,
   output logic [ADDRWIDTH-1:0]             addr,
   output logic                             read_en,
   output logic                             write_en,
   output logic [strb_width(DATAWIDTH)-1:0] byte_strobe,
   output logic [DATAWIDTH-1:0]             wdata,
   input  logic [DATAWIDTH-1:0]             rdata,
   input  logic                             reg_ready
);

   localparam int unsigned          STRB_W       = strb_width(DATAWIDTH);
   localparam logic [ADDRWIDTH-1:0] ADDR_LIMIT_C = ADDRWIDTH'(ADDR_LIMIT);

   state_e                 state_q, state_d;
   logic [ADDRWIDTH-1:0]   addr_q, addr_d;
   logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]      strb_q, strb_d;
   logic                   pwrite_q, pwrite_d;
   logic                   err_q, err_d;
   logic                   read_en_q, read_en_d;
   logic                   write_en_q, write_en_d;
   logic                   pready_q, pready_d;
   logic                   pslverr_q, pslverr_d;
   logic [DATAWIDTH-1:0]   prdata_q, prdata_d;
   logic                   ready_seen_q, ready_seen_d;
   logic [DATAWIDTH-1:0]   rdata_hold_q, rdata_hold_d;

   logic cnt_clr, cnt_en, min_done, cnt_timeout;
   logic setup_err;
   logic ready_hit;
   logic pprot_unused;

   // Access rejected at setup time: it never reaches the register bank.
`ifdef APB4_SLV_PPROT_CHECK_EN
   assign setup_err    = (paddr > ADDR_LIMIT_C) || (pwrite && !pprot[0]);
   assign pprot_unused = ^pprot[2:1];
`else
   assign setup_err    = (paddr > ADDR_LIMIT_C);
   assign pprot_unused = ^pprot;
`endif

   // A reg_ready seen while minimum wait states are still running counts.
   assign ready_hit = reg_ready || ready_seen_q;

   apb4_slv_wait_cnt #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .TIMEOUT     (TIMEOUT)
   ) u_wait_cnt (
      .pclk     (pclk),
      .preset   (preset),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .min_done (min_done),
      .timeout  (cnt_timeout)
   );

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      strb_d       = strb_q;
      pwrite_d     = pwrite_q;
      err_d        = err_q;
      read_en_d    = 1'b0;
      write_en_d   = 1'b0;
      pready_d     = 1'b0;
      pslverr_d    = RESP_OKAY;
      prdata_d     = prdata_q;
      ready_seen_d = ready_seen_q;
      rdata_hold_d = rdata_hold_q;
      cnt_clr      = 1'b0;
      cnt_en       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // The counter is cleared here so it reads 0 during REQ.
            cnt_clr      = 1'b1;
            ready_seen_d = 1'b0;
            if (psel && !penable) begin
               addr_d     = paddr;
               pwrite_d   = pwrite;
               wdata_d    = pwdata;
               strb_d     = pwrite ? pstrb : '0;
               err_d      = setup_err;
               // Request pulses are registered, so they are raised on the
               // edge that enters REQ and are visible for exactly that cycle.
               read_en_d  = !pwrite && !setup_err;
               write_en_d = pwrite && !setup_err;
               state_d    = ST_REQ;
            end
         end

         ST_REQ, ST_WAIT: begin
            cnt_en = 1'b1;
            if (!psel) begin
               // Master abandoned the transfer: no response is issued.
               state_d      = ST_IDLE;
               ready_seen_d = 1'b0;
            end else if (err_q) begin
               state_d   = ST_RESP;
               pready_d  = 1'b1;
               pslverr_d = RESP_SLVERR;
               prdata_d  = '0;
            end else if (ready_hit && min_done) begin
               // reg_ready beats the timeout when both land in one cycle.
               state_d   = ST_RESP;
               pready_d  = 1'b1;
               pslverr_d = RESP_OKAY;
               if (pwrite_q) begin
                  prdata_d = '0;
               end else begin
                  prdata_d = reg_ready ? rdata : rdata_hold_q;
               end
            end else if (cnt_timeout) begin
               state_d   = ST_RESP;
               pready_d  = 1'b1;
               pslverr_d = RESP_SLVERR;
               prdata_d  = '0;
            end else begin
               state_d = ST_WAIT;
               if (reg_ready) begin
                  ready_seen_d = 1'b1;
                  rdata_hold_d = rdata;
               end
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         strb_q       <= '0;
         pwrite_q     <= 1'b0;
         err_q        <= 1'b0;
         read_en_q    <= 1'b0;
         write_en_q   <= 1'b0;
         pready_q     <= 1'b0;
         pslverr_q    <= RESP_OKAY;
         prdata_q     <= '0;
         ready_seen_q <= 1'b0;
         rdata_hold_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         strb_q       <= strb_d;
         pwrite_q     <= pwrite_d;
         err_q        <= err_d;
         read_en_q    <= read_en_d;
         write_en_q   <= write_en_d;
         pready_q     <= pready_d;
         pslverr_q    <= pslverr_d;
         prdata_q     <= prdata_d;
         ready_seen_q <= ready_seen_d;
         rdata_hold_q <= rdata_hold_d;
      end
   end

   assign prdata      = prdata_q;
   assign pready      = pready_q;
   assign pslverr     = pslverr_q;
   assign addr        = addr_q;
   assign read_en     = read_en_q;
   assign write_en    = write_en_q;
   assign byte_strobe = strb_q;
   assign wdata       = wdata_q;

endmodule

// File: tb/tb_apb4_slave_if_ws.sv
// -----------------------------------------------------------------------------
// tb_apb4_slave_if_ws
// Two instances share the APB/register stimulus: index 0 has WAIT_CYCLES=0,
// index 1 has WAIT_CYCLES=3; both use ADDR_LIMIT='h7FC and TIMEOUT=16.
// Latencies are counted in cycles from the setup cycle (T0) to the cycle in
// which pready is sampled high.
// -----------------------------------------------------------------------------
module tb_apb4_slave_if_ws;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int SW = 4;

   logic          pclk = 1'b0;
   logic          preset;
   logic [AW-1:0] paddr;
   logic          penable;
   logic          pwrite;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic [2:0]    pprot;
   logic [DW-1:0] rdata;
   logic          reg_ready;

   logic          psel_w     [2];
   logic [DW-1:0] prdata_w   [2];
   logic          pready_w   [2];
   logic          pslverr_w  [2];
   logic [AW-1:0] addr_w     [2];
   logic          read_en_w  [2];
   logic          write_en_w [2];
   logic [SW-1:0] strb_w     [2];
   logic [DW-1:0] wdata_w    [2];

   int tests = 0;
   int fails = 0;

   always #5 pclk = ~pclk;

   apb4_slave_if_ws #(
      .ADDRWIDTH(AW), .DATAWIDTH(DW), .ADDR_LIMIT('h7FC), .WAIT_CYCLES(0), .TIMEOUT(16)
   ) u_dut0 (
      .pclk(pclk), .preset(preset), .psel(psel_w[0]), .paddr(paddr), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata_w[0]), .pready(pready_w[0]), .pslverr(pslverr_w[0]),
      .addr(addr_w[0]), .read_en(read_en_w[0]), .write_en(write_en_w[0]),
      .byte_strobe(strb_w[0]), .wdata(wdata_w[0]), .rdata(rdata), .reg_ready(reg_ready)
   );

   apb4_slave_if_ws #(
      .ADDRWIDTH(AW), .DATAWIDTH(DW), .ADDR_LIMIT('h7FC), .WAIT_CYCLES(3), .TIMEOUT(16)
   ) u_dut3 (
      .pclk(pclk), .preset(preset), .psel(psel_w[1]), .paddr(paddr), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata_w[1]), .pready(pready_w[1]), .pslverr(pslverr_w[1]),
      .addr(addr_w[1]), .read_en(read_en_w[1]), .write_en(write_en_w[1]),
      .byte_strobe(strb_w[1]), .wdata(wdata_w[1]), .rdata(rdata), .reg_ready(reg_ready)
   );

   // One transfer: stimulus plus the response it must produce.
   // rdy_dly: reg_ready rises in cycle T(1+rdy_dly); -1 = never.
   // rdy_pulse: reg_ready high for that single cycle only (rdata then changes).
   typedef struct {
      int            dut;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic [2:0]    prot;
      logic [DW-1:0] rd;
      int            rdy_dly;
      bit            rdy_pulse;
      int            exp_lat;
      logic          exp_err;
      int            exp_pulses;
   } vec_t;

   vec_t vecs [14];
   vec_t exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int dut, input logic wr, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [SW-1:0] s,
                               input logic [2:0] prot, input logic [DW-1:0] rd,
                               input int dly, input bit pulse, input int lat,
                               input logic err, input int pulses);
      vec_t v;
      v.dut = dut; v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.prot = prot;
      v.rd = rd; v.rdy_dly = dly; v.rdy_pulse = pulse; v.exp_lat = lat;
      v.exp_err = err; v.exp_pulses = pulses;
      return v;
   endfunction

   function automatic logic rdy_at(input vec_t v, input int k);
      if (v.rdy_dly < 0) return 1'b0;
      if (v.rdy_pulse) return (k == 1 + v.rdy_dly);
      return (k >= 1 + v.rdy_dly);
   endfunction

   // Entered and left at #1 after a rising edge; the next call may start a
   // setup immediately, giving back-to-back transfers.
   task automatic xfer(input vec_t v, input string tag);
      bit            got;
      bit            viol;
      int            lat, pulses, wrong;
      logic          err;
      logic [DW-1:0] prd;
      logic [AW-1:0] addr_r;
      logic [SW-1:0] strb_r;
      logic [DW-1:0] wdata_r;
      vec_t          e;
      got = 0; viol = 0; lat = 0; pulses = 0; wrong = 0; err = 0; prd = '0;
      addr_r = '0; strb_r = '0; wdata_r = '0;
      exp_q.push_back(v);
      psel_w[v.dut] = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr;
      pwdata = v.data; pstrb = v.strb; pprot = v.prot; reg_ready = 1'b0; rdata = '0;
      @(negedge pclk);
      check({tag, " idle_resp"}, 32'({pready_w[v.dut], pslverr_w[v.dut]}), 32'd0);
      for (int k = 1; k <= 40 && !got; k++) begin
         @(posedge pclk); #1;
         penable   = 1'b1;
         reg_ready = rdy_at(v, k);
         rdata     = (v.rdy_pulse && v.rdy_dly >= 0 && k > 1 + v.rdy_dly) ? 32'hDEAD_BEEF : v.rd;
         @(negedge pclk);
         if (read_en_w[v.dut] || write_en_w[v.dut]) begin
            if (k == 1 && ((v.wr && write_en_w[v.dut]) || (!v.wr && read_en_w[v.dut])))
               pulses++;
            else
               wrong++;
         end
         if (pslverr_w[v.dut] && !pready_w[v.dut]) viol = 1;
         if (k == 1) begin
            addr_r = addr_w[v.dut]; strb_r = strb_w[v.dut]; wdata_r = wdata_w[v.dut];
         end
         if (pready_w[v.dut]) begin
            got = 1; lat = k; err = pslverr_w[v.dut]; prd = prdata_w[v.dut];
         end
      end
      check({tag, " pready_seen"}, 32'(got), 32'd1);
      e = exp_q.pop_front();
      check({tag, " latency"}, lat, e.exp_lat);
      check({tag, " pslverr"}, 32'(err), 32'(e.exp_err));
      if (!e.wr) check({tag, " prdata"}, prd, e.exp_err ? 32'd0 : e.rd);
      check({tag, " req_pulse"}, pulses, e.exp_pulses);
      check({tag, " stray_pulse"}, wrong, 0);
      check({tag, " slverr_wo_ready"}, 32'(viol), 32'd0);
      if (e.exp_pulses != 0) begin
         check({tag, " addr"}, 32'(addr_r), 32'(e.addr));
         check({tag, " byte_strobe"}, 32'(strb_r), e.wr ? 32'(e.strb) : 32'd0);
         if (e.wr) check({tag, " wdata"}, wdata_r, e.data);
      end
      @(posedge pclk); #1;
      psel_w[v.dut] = 1'b0; penable = 1'b0; reg_ready = 1'b0;
   endtask

   task automatic idle_watch(input int dut, input int n, output int rdy_cnt, output int en_cnt);
      rdy_cnt = 0; en_cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge pclk);
         if (pready_w[dut] || pslverr_w[dut]) rdy_cnt++;
         if (read_en_w[dut] || write_en_w[dut]) en_cnt++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc, ec;
      vecs[0]  = mk(0, 1'b1, 12'h010, 32'hA5A5_0001, 4'hF, 3'b001, 32'h0,         0,  0, 2,  1'b0, 1);
      vecs[1]  = mk(0, 1'b0, 12'h020, 32'h0,         4'hF, 3'b001, 32'hCAFE_F00D, 0,  0, 2,  1'b0, 1);
      vecs[2]  = mk(0, 1'b0, 12'h040, 32'h0,         4'h0, 3'b001, 32'h1122_3344, 4,  0, 6,  1'b0, 1);
      vecs[3]  = mk(1, 1'b0, 12'h020, 32'h0,         4'h0, 3'b001, 32'h1234_5678, 0,  0, 5,  1'b0, 1);
      vecs[4]  = mk(1, 1'b1, 12'h100, 32'h0BAD_F00D, 4'h5, 3'b001, 32'h0,         0,  0, 5,  1'b0, 1);
      vecs[5]  = mk(1, 1'b0, 12'h024, 32'h0,         4'h0, 3'b001, 32'h89AB_CDEF, 1,  1, 5,  1'b0, 1);
      vecs[6]  = mk(1, 1'b0, 12'h028, 32'h0,         4'h0, 3'b001, 32'h0F0F_0F0F, 6,  0, 8,  1'b0, 1);
      vecs[7]  = mk(0, 1'b1, 12'h7FC, 32'h0000_0077, 4'h1, 3'b001, 32'h0,         0,  0, 2,  1'b0, 1);
      vecs[8]  = mk(0, 1'b1, 12'h800, 32'h0000_0099, 4'hF, 3'b001, 32'h0,         -1, 0, 2,  1'b1, 0);
      vecs[9]  = mk(1, 1'b0, 12'hFFC, 32'h0,         4'h0, 3'b001, 32'h4444_4444, -1, 0, 2,  1'b1, 0);
      vecs[10] = mk(1, 1'b0, 12'h030, 32'h0,         4'h0, 3'b001, 32'hFFFF_FFFF, -1, 0, 18, 1'b1, 1);
      vecs[11] = mk(0, 1'b0, 12'h034, 32'h0,         4'h0, 3'b001, 32'h600D_CAFE, 16, 0, 18, 1'b0, 1);
      vecs[12] = mk(0, 1'b0, 12'h038, 32'h0,         4'h0, 3'b001, 32'h0BAD_BEEF, 17, 0, 18, 1'b1, 1);
`ifdef APB4_SLV_PPROT_CHECK_EN
      vecs[13] = mk(0, 1'b1, 12'h010, 32'h0000_0013, 4'hF, 3'b000, 32'h0,         0,  0, 2,  1'b1, 0);
`else
      vecs[13] = mk(0, 1'b1, 12'h010, 32'h0000_0013, 4'hF, 3'b000, 32'h0,         0,  0, 2,  1'b0, 1);
`endif

      preset = 1'b1; psel_w[0] = 1'b0; psel_w[1] = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001; rdata = '0; reg_ready = 1'b0;
      repeat (3) @(negedge pclk);
      preset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset%0d pready", d), 32'(pready_w[d]), 32'd0);
         check($sformatf("reset%0d pslverr", d), 32'(pslverr_w[d]), 32'd0);
         check($sformatf("reset%0d prdata", d), prdata_w[d], 32'd0);
         check($sformatf("reset%0d req_en", d), 32'({read_en_w[d], write_en_w[d]}), 32'd0);
         check($sformatf("reset%0d addr", d), 32'(addr_w[d]), 32'd0);
         check($sformatf("reset%0d wdata", d), wdata_w[d], 32'd0);
         check($sformatf("reset%0d byte_strobe", d), 32'(strb_w[d]), 32'd0);
      end
      @(posedge pclk); #1;

      // Table: every transfer starts in the cycle right after the previous RESP.
      for (int i = 0; i < 14; i++) xfer(vecs[i], $sformatf("vec%0d", i));

      // Abort: psel dropped during WAIT, then a late reg_ready.
      psel_w[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h030; pprot = 3'b001;
      reg_ready = 1'b0;
      @(posedge pclk); #1; penable = 1'b1;
      @(negedge pclk);
      check("abort req read_en", 32'(read_en_w[1]), 32'd1);
      rc = 32'(pready_w[1]);
      @(posedge pclk); #1;
      @(negedge pclk);
      rc += 32'(pready_w[1]);
      @(posedge pclk); #1;
      psel_w[1] = 1'b0; penable = 1'b0; reg_ready = 1'b1; rdata = 32'h5555_AAAA;
      idle_watch(1, 20, ec, ec);
      idle_watch(1, 1, rc, ec);
      rc = 0;
      idle_watch(1, 20, rc, ec);
      check("abort pready", rc, 0);
      check("abort late req_en", ec, 0);
      @(posedge pclk); #1;
      xfer(mk(1, 1'b0, 12'h02C, 32'h0, 4'h0, 3'b001, 32'h0A0B_0C0D, 5, 0, 7, 1'b0, 1), "post_abort");

      // Asynchronous reset in the middle of WAIT.
      psel_w[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h030; reg_ready = 1'b0;
      @(posedge pclk); #1; penable = 1'b1;
      @(posedge pclk); #1;
      @(posedge pclk); #3;
      preset = 1'b1;
      #1;
      check("rst_mid pready", 32'(pready_w[1]), 32'd0);
      check("rst_mid prdata", prdata_w[1], 32'd0);
      check("rst_mid addr", 32'(addr_w[1]), 32'd0);
      check("rst_mid req_en", 32'({read_en_w[1], write_en_w[1]}), 32'd0);
      @(negedge pclk);
      psel_w[1] = 1'b0; penable = 1'b0; preset = 1'b0;
      idle_watch(1, 20, rc, ec);
      check("rst_mid no_response", rc, 0);
      check("rst_mid no_request", ec, 0);
      @(posedge pclk); #1;
      xfer(mk(1, 1'b1, 12'h044, 32'hFACE_0042, 4'hC, 3'b001, 32'h0, 0, 0, 5, 1'b0, 1), "post_reset");

      @(negedge pclk);
      check("final idle0", 32'({pready_w[0], pslverr_w[0]}), 32'd0);
      check("final idle1", 32'({pready_w[1], pslverr_w[1]}), 32'd0);
      check("scoreboard empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
